// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // All per-channel counters share one width. It is wide enough for the largest terminal count.
  function automatic int cnt_width(input int debounce, input int delay, input int period);
    int m;
    m = debounce;
    if (delay > m) m = delay;
    if (period > m) m = period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debounce FSM, auto-repeat counters, registered events.
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_raw,
  input  logic mask,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  logic            s1, s2;
  key_state_t      state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [CW-1:0]   hold, hold_next;
  logic [CW-1:0]   per, per_next;
  logic            level_next, press_next, release_next;
  logic            rep_due;

  // The input is already normalised (1 = pressed), so 0 is the released level and no event follows reset.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pressed_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      hold          <= '0;
      per           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      hold          <= hold_next;
      per           <= per_next;
      level         <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // The first repeat fires when hold reaches the delay. Later repeats come from the period counter once hold has saturated.
  assign rep_due = (REPEAT_DELAY > 0) &&
                   (((hold != RD_LAST) && (hold + CW'(1) == RD_LAST)) ||
                    ((hold == RD_LAST) && (per == PER_LAST)));

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hold_next  = hold;
    per_next   = per;
    unique case (state)
      RELEASED: begin
        if (s2) begin
          state_next = PRESS_WAIT;
          cnt_next   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          hold_next  = '0;
          per_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CW'(1);
        end else if (REPEAT_DELAY > 0) begin
          if (hold != RD_LAST) hold_next = hold + CW'(1);
          else                 per_next  = (per == PER_LAST) ? '0 : per + CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed keeps hold/per, so the repeat cadence resumes where it paused.
        if (s2) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
          hold_next  = '0;
          per_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
    endcase
    if (mask) begin
      state_next = RELEASED;
      cnt_next   = '0;
      hold_next  = '0;
      per_next   = '0;
    end
  end

  always_comb begin
    press_next   = 1'b0;
    release_next = 1'b0;
    level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    if (mask) begin
      release_next = (state == PRESSED) || (state == RELEASE_WAIT);
    end else begin
      case (state)
        PRESS_WAIT:   press_next   = s2 && (cnt == DB_LAST);
        PRESSED:      press_next   = s2 && rep_due;
        RELEASE_WAIT: release_next = !s2 && (cnt == DB_LAST);
        default:      ;
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel pushbutton conditioner: polarity normalisation and mask fan-out around N_KEYS independent channels.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW_IN   = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] Key_In,
  input  logic [N_KEYS-1:0] Mask,
  output logic [N_KEYS-1:0] Level_Out,
  output logic [N_KEYS-1:0] Press_Pulse,
  output logic [N_KEYS-1:0] Release_Pulse
);

  logic [N_KEYS-1:0] pressed_raw;

  // Inverting ahead of the synchroniser is equivalent to resetting the flops to the released pin level.
  assign pressed_raw = (ACTIVE_LOW_IN != 0) ? ~Key_In : Key_In;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("key_conditioner: REPEAT_PERIOD must be >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (Clk),
      .rst_n        (Reset),
      .pressed_raw  (pressed_raw[i]),
      .mask         (Mask[i]),
      .level        (Level_Out[i]),
      .press_pulse  (Press_Pulse[i]),
      .release_pulse(Release_Pulse[i])
    );
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Parametrised multi-channel pushbutton conditioner for the SLC-3 toplevel.
- Replaces ad-hoc Run/Continue/Reset sampling with one block per board.
- Each raw key gets:
  - synchronisation and polarity normalisation;
  - debouncing;
  - press/release one-shot pulses;
  - optional auto-repeat.
- Sits between board pins and the ISDU/IO logic, which consume clean single-cycle events instead of levels.

Parameters:
- N_KEYS, 2: number of independent key channels.
- DEBOUNCE_CYCLES, 16: consecutive stable samples required beyond the first. Must be >= 1; elaboration error if 0.
- ACTIVE_LOW_IN, 1: 1 = raw key reads 0 when pressed (DE2 KEY style); 0 = active high.
- REPEAT_DELAY, 0: cycles from the debounced press to the first auto-repeat pulse. 0 disables auto-repeat.
- REPEAT_PERIOD, 8: cycles between subsequent auto-repeat pulses. Must be >= 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset; 0 resets all state.
- Key_In  in  N_KEYS  raw asynchronous key pins.
- Mask  in  N_KEYS  1 = channel forced released.
- Level_Out  out  N_KEYS  debounced pressed level, 1 = pressed.
- Press_Pulse  out  N_KEYS  one-cycle pulse on debounced press and on each auto-repeat.
- Release_Pulse  out  N_KEYS  one-cycle pulse on debounced release.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-low; Reset=0 clears all state immediately.
- Reset values:
  - all outputs 0;
  - every channel in RELEASED;
  - counters 0;
  - synchroniser flops at the "released" raw level (1 if ACTIVE_LOW_IN else 0), so no pulse appears at reset release.
- Synchroniser: two flops per channel. s2 is the normalised sample, 1 = pressed.
- Per-channel FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED:
  - s2=1 -> PRESS_WAIT, cnt=1.
- PRESS_WAIT:
  - s2=0 -> RELEASED, cnt=0, no pulse (glitch rejected).
  - s2=1 and cnt<DEBOUNCE_CYCLES -> cnt++.
  - s2=1 and cnt==DEBOUNCE_CYCLES -> PRESSED; Level_Out=1, Press_Pulse=1 for one cycle; hold=0.
- PRESSED:
  - s2=0 -> RELEASE_WAIT, cnt=1; Level_Out stays 1.
  - otherwise, if REPEAT_DELAY>0:
    - hold increments and saturates;
    - pulse when hold reaches REPEAT_DELAY;
    - thereafter pulse every REPEAT_PERIOD cycles while held.
- RELEASE_WAIT:
  - s2=1 -> back to PRESSED; the repeat counter resumes without reset and no pulse is emitted.
  - s2=0 and cnt==DEBOUNCE_CYCLES -> RELEASED; Level_Out=0, Release_Pulse=1 for one cycle.
  - s2=0 otherwise -> cnt++.
- Latency: a raw change first sampled at edge k makes Level_Out change and the pulse assert after edge k+2+DEBOUNCE_CYCLES. A raw level held for DEBOUNCE_CYCLES or fewer sampling edges produces no event.
- All outputs are registered.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). No wrap; hold saturates.
- Mask:
  - Mask=1 forces next state RELEASED and clears counters.
  - If the channel was PRESSED or RELEASE_WAIT, Release_Pulse=1 once and Level_Out=0.
  - If the channel was RELEASED or PRESS_WAIT, no pulse.
  - Mask wins over a simultaneous debounce completion.
  - After Mask falls, a still-held key needs a full debounce and then yields Press_Pulse.
- Channels are fully independent. Simultaneous events on different channels all assert in the same cycle.
- Press_Pulse and Release_Pulse are never both 1 on one channel in the same cycle.
- Reset mid-press: the channel returns to RELEASED. A key still held after reset release is re-debounced and produces a fresh Press_Pulse.

Decomposition:
- Package key_cond_pkg:
  - key_state_t enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - function cnt_width() for counter sizing.
- Sub-module key_channel: one synchroniser + FSM + counters, instantiated N_KEYS times by a generate loop in key_conditioner.
- The top only handles polarity, Mask fan-out and parameter checks.

Test Plan (N_KEYS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW_IN=1, REPEAT_PERIOD=8 unless stated):
1. Reset=0 then 1, Key_In=2'b11 held 20 cycles -> all outputs 0 throughout; no pulse at reset release.
2. Key_In[0]=0 from edge 10 onward -> Level_Out[0] rises and Press_Pulse[0]=1 for exactly one cycle after edge 16. Key_In[0]=1 from edge 40 -> Release_Pulse[0] one cycle after edge 46.
3. Key_In[1]=0 for 4 edges, then 1 (glitch) -> no Press_Pulse[1]; Level_Out[1] stays 0. Same with 5 edges -> press detected.
4. REPEAT_DELAY=20, key 0 held 60 cycles after the press pulse -> Press_Pulse[0] at +0, +20, +28, +36, +44, +52 cycles.
5. Key 0 pressed and debounced, Mask[0]=1 on the same edge key 1 completes debounce -> Release_Pulse[0] and Press_Pulse[1] in the same cycle. Mask[0]=0 with key held -> new Press_Pulse[0] 5 cycles later.
6. Reset asserted for 3 cycles while key 0 held and Level_Out[0]=1 -> outputs 0 immediately (asynchronously). After release, Press_Pulse[0] fires after edge 6.
